// File: rtl/lane_reader_pkg.sv
// Shared defaults, counter widths and FSM state encoding for lane_reader.
// Optional feature macro: LANE_READER_PARITY_EN (see lane_reader.sv).
package lane_reader_pkg;
    localparam int ROWS_DEF = 64;
    localparam int COLS_DEF = 25;
    localparam int ROW_W    = $clog2(ROWS_DEF);
    localparam int COL_W    = $clog2(COLS_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_e;
endpackage

// File: rtl/lane_reader_if.sv
// Load/stream handshake bundle for lane_reader; out_parity exists only when
// LANE_READER_PARITY_EN is defined.
interface lane_reader_if
    import lane_reader_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
);
    logic                     start;
    logic                     load_valid;
    logic                     load_ready;
    logic [COLS-1:0]          load_row;
    logic                     out_valid;
    logic                     out_ready;
    logic [ROWS-1:0]          nOut;
    logic [$clog2(COLS)-1:0]  out_number;
    logic                     busy;
    logic                     done;
`ifdef LANE_READER_PARITY_EN
    logic                     out_parity;
`endif

    modport master (
        output start, load_valid, load_row, out_ready,
`ifdef LANE_READER_PARITY_EN
        input  out_parity,
`endif
        input  load_ready, out_valid, nOut, out_number, busy, done
    );

    modport slave (
        input  start, load_valid, load_row, out_ready,
`ifdef LANE_READER_PARITY_EN
        output out_parity,
`endif
        output load_ready, out_valid, nOut, out_number, busy, done
    );
endinterface

// File: rtl/lane_reader_column_mux.sv
// Combinational column select: o_col[n] = i_rows[n][COLS-1-i_col].
// Column 0 is the MSB of each row.
module column_mux
    import lane_reader_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int CW   = $clog2(COLS)
) (
    input  logic [ROWS-1:0][COLS-1:0] i_rows,
    input  logic [CW-1:0]             i_col,
    output logic [ROWS-1:0]           o_col
);
    logic [CW-1:0] w_bit;

    assign w_bit = CW'(COLS - 1) - i_col;

    for (genvar n = 0; n < ROWS; n++) begin : g_row
        assign o_col[n] = i_rows[n][w_bit];
    end
endmodule

// File: rtl/lane_reader.sv
// Loads ROWS rows of COLS bits, then streams them back column by column.
// Define LANE_READER_PARITY_EN to add the registered out_parity output.
module lane_reader
    import lane_reader_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    lane_reader_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    state_e                    r_state;
    logic [RW-1:0]             r_row_cnt;
    logic [CW-1:0]             r_col_cnt;
    logic [ROWS-1:0][COLS-1:0] r_rows;
    logic [ROWS-1:0][COLS-1:0] w_rows_nxt;
    logic [ROWS-1:0]           r_nout;
    logic [ROWS-1:0]           w_col_data;
    logic [CW-1:0]             w_col_sel;
    logic                      w_load_hs;
    logic                      w_last_row;
    logic                      w_out_hs;
    logic                      w_last_col;
    logic                      w_col_load;

    assign w_load_hs  = (r_state == LOAD) && bus.load_valid;
    assign w_last_row = w_load_hs && (r_row_cnt == RW'(ROWS - 1));
    assign w_out_hs   = (r_state == STREAM) && bus.out_ready;
    assign w_last_col = w_out_hs && (r_col_cnt == CW'(COLS - 1));
    assign w_col_load = w_last_row || (w_out_hs && !w_last_col);

    // Column 0 must be registered on the same edge that stores the last row,
    // so the mux looks at storage with the pending write already applied.
    always_comb begin
        w_rows_nxt = r_rows;
        if (w_load_hs) w_rows_nxt[r_row_cnt] = bus.load_row;
    end

    assign w_col_sel = w_last_row ? '0 : r_col_cnt + CW'(1);

    column_mux #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) u_column_mux (
        .i_rows (w_rows_nxt),
        .i_col  (w_col_sel),
        .o_col  (w_col_data)
    );

    // Row storage is deliberately left out of reset so it survives an abort.
    always_ff @(posedge clk) begin
        r_rows <= w_rows_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_row_cnt <= '0;
            r_col_cnt <= '0;
            r_nout    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state   <= LOAD;
                        r_row_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (w_load_hs) begin
                        if (w_last_row) begin
                            r_state   <= STREAM;
                            r_col_cnt <= '0;
                        end else begin
                            r_row_cnt <= r_row_cnt + RW'(1);
                        end
                    end
                end
                STREAM: begin
                    if (w_out_hs) begin
                        if (w_last_col) begin
                            r_state   <= DONE;
                            r_col_cnt <= '0;
                        end else begin
                            r_col_cnt <= r_col_cnt + CW'(1);
                        end
                    end
                end
                DONE: r_state <= IDLE;
            endcase

            if (w_col_load)      r_nout <= w_col_data;
            else if (w_last_col) r_nout <= '0;
        end
    end

`ifdef LANE_READER_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_parity <= 1'b0;
        else if (w_col_load) r_parity <= ^w_col_data;
        else if (w_last_col) r_parity <= 1'b0;
    end

    assign bus.out_parity = r_parity;
`endif

    assign bus.load_ready = (r_state == LOAD);
    assign bus.out_valid  = (r_state == STREAM);
    assign bus.nOut       = r_nout;
    assign bus.out_number = r_col_cnt;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = (r_state == DONE);
endmodule
